histogram_cdf_reader: RTL and testbench
=======================================

Name: histogram_cdf_reader

Overview:
Reader side of the grey-level histogram RAM. After a frame has been accumulated, it sweeps the 256 bins through the histogram's read port and forms the running cumulative distribution (CDF). It scales each CDF value to an 8-bit equalisation code and writes it into the downstream equalisation LUT. It then drives the histogram clear for a fixed number of cycles so the RAM is ready for the next frame.

Parameters:
RD_LATENCY, 2, cycles from oRdAddr presented to iRdData valid (range 1..4)
BIN_W, 20, width of one histogram bin / CDF accumulator
SCALE, 11141, fixed-point reciprocal = round(2^24*255/384000) for an 800x480 frame
SHIFT, 24, right shift applied after multiply
CLEAR_CYCLES, 300, cycles oHistoClear is held high after the sweep

Ports:
iClk  in  1  system clock, all logic rising-edge
iRst_n  in  1  asynchronous active-low reset
iStart  in  1  single-cycle request to begin a sweep; honoured only in IDLE
oRdAddr  out  8  bin address to histogram read port (drives its iGray)
iRdData  in  BIN_W  bin count returned RD_LATENCY cycles after oRdAddr
oHistoClear  out  1  drives histogram iClear
oHistoLock  out  1  high whenever not IDLE; upstream must hold histogram iInc low
oLutWe  out  1  LUT write strobe
oLutAddr  out  8  LUT write address (= bin index)
oLutData  out  8  equalised grey code
oCdfTotal  out  BIN_W  final CDF (total pixel count); held until next sweep
oBusy  out  1  high from cycle after accepted iStart until oDone
oDone  out  1  one-cycle pulse at end of CLEAR phase

Behaviour:
- Reset (async, iRst_n=0): state IDLE, all outputs 0, accumulator 0, valid pipe flushed. Reset mid-sweep aborts immediately; no further LUT writes; oHistoClear drops at once.
- States: IDLE -> ISSUE on iStart. ISSUE -> DRAIN after address 255 is issued. DRAIN -> CLEAR after LUT[255] is written. CLEAR -> IDLE after CLEAR_CYCLES cycles, with oDone pulsed on the final CLEAR cycle.
- ISSUE: the cycle after iStart, oRdAddr=0; it increments by 1 each cycle to 255 (256 cycles, no stalls). A RD_LATENCY-deep valid shift register tags returning data.
- Accumulate: on tagged-valid data, acc <= acc + iRdData. The accumulator is cleared on iStart acceptance.
- Scale stage (registered): p = acc*SCALE + 2^(SHIFT-1), width BIN_W+14. code = p>>SHIFT, saturated to 255 if the result exceeds 255.
- Write: oLutWe=1 with oLutAddr=k, oLutData=code(k). This occurs exactly RD_LATENCY+2 cycles after oRdAddr=k was presented. There are 256 consecutive write cycles and no gaps.
- oCdfTotal is updated when LUT[255] is written.
- Accumulator width: CDF wraps mod 2^BIN_W; wrap is not detected (max legal frame is 384000 < 2^20).
- CLEAR: oHistoClear=1 for exactly CLEAR_CYCLES cycles; oLutWe=0 throughout.
- iStart while not IDLE is ignored. iStart on the same cycle as oDone is ignored; it is accepted on the following IDLE cycle.
- oRdAddr holds 255 during DRAIN/CLEAR and returns to 0 in IDLE.
- oHistoLock = (state != IDLE).

Test Plan:
- Reset release then iStart; histogram model with all 384000 pixels in bin 0 -> LUT[0..255] all 255; oCdfTotal=384000; 256 writes; oDone exactly 1+256+RD_LATENCY+2+CLEAR_CYCLES cycles after iStart (within ±1 per state-transition convention, checked as fixed constant).
- Uniform 1500 per bin -> LUT[0]=1, LUT[255]=255, codes monotonic non-decreasing; oCdfTotal=384000.
- All pixels in bin 200 -> LUT[0..199]=0, LUT[200..255]=255.
- Overfull frame (2000 per bin, total 512000) -> codes saturate at 255 from the first bin where scaled CDF exceeds 255; no wrap of oLutData.
- iStart pulsed mid-ISSUE and during CLEAR -> ignored, write count stays 256, no restart. Repeat with RD_LATENCY=1 and 4 -> write timing shifts accordingly.
- Assert iRst_n low at bin 100 -> all outputs 0 asynchronously, no further writes. Re-start after release -> full correct sweep.

Source files
------------

// File: rtl/histogram_cdf_reader.sv
// histogram_cdf_reader
//   Reader side of the grey-level histogram RAM. After a frame has been
//   accumulated it sweeps bins 0..255 through the histogram read port and
//   forms the running CDF. Each CDF value is scaled to an 8-bit
//   equalisation code, which is written into the downstream LUT. The
//   histogram clear is then held for CLEAR_CYCLES cycles.
//
// Ports
//   iClk        system clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iStart      single-cycle sweep request, honoured only in IDLE
//   oRdAddr     bin address to the histogram read port
//   iRdData     bin count, valid RD_LATENCY cycles after oRdAddr
//   oHistoClear histogram clear, high for CLEAR_CYCLES cycles after the sweep
//   oHistoLock  high whenever not IDLE (upstream must hold iInc low)
//   oLutWe      LUT write strobe
//   oLutAddr    LUT write address (bin index)
//   oLutData    equalised grey code
//   oCdfTotal   final CDF (total pixel count), held until the next sweep
//   oBusy       high from the cycle after an accepted iStart until oDone
//   oDone       one-cycle pulse on the final CLEAR cycle
module histogram_cdf_reader #(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned BIN_W        = 20,
  parameter int unsigned SCALE        = 11141,
  parameter int unsigned SHIFT        = 24,
  parameter int unsigned CLEAR_CYCLES = 300
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  output logic [7:0]       oRdAddr,
  input  logic [BIN_W-1:0] iRdData,
  output logic             oHistoClear,
  output logic             oHistoLock,
  output logic             oLutWe,
  output logic [7:0]       oLutAddr,
  output logic [7:0]       oLutData,
  output logic [BIN_W-1:0] oCdfTotal,
  output logic             oBusy,
  output logic             oDone
);

  localparam int unsigned P_W   = BIN_W + 14;
  localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [P_W-1:0]   ROUND    = P_W'(1) << (SHIFT - 1);
  localparam logic [P_W-1:0]   SCALE_P  = P_W'(SCALE);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CLEAR
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [RD_LATENCY-1:0] r_vld_pipe;
  logic [BIN_W-1:0]      r_acc;
  logic                  r_acc_vld;
  logic [7:0]            r_acc_idx;
  logic [7:0]            r_in_idx;
  logic [CNT_W-1:0]      r_clr_cnt;
  logic                  r_last_wr;

  logic                  w_accept;
  logic                  w_clear_end;
  logic                  w_in_vld;
  logic [P_W-1:0]        w_prod;
  logic [P_W-1:0]        w_code_full;
  logic [7:0]            w_code;

  assign w_accept    = (r_state == IDLE) && iStart;
  assign w_clear_end = (r_state == CLEAR) && (r_clr_cnt == CLR_LAST);
  assign w_in_vld    = r_vld_pipe[RD_LATENCY-1];

  // Scale the running CDF with rounding, then saturate to an 8-bit code.
  always_comb begin
    w_prod      = P_W'(r_acc) * SCALE_P + ROUND;
    w_code_full = w_prod >> SHIFT;
    w_code      = (w_code_full > P_W'(255)) ? 8'hFF : w_code_full[7:0];
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    oHistoClear = 1'b0;
    oHistoLock  = 1'b0;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (iStart) w_next = ISSUE;
      end
      ISSUE: begin
        oHistoLock = 1'b1;
        oBusy      = 1'b1;
        if (oRdAddr == 8'hFF) w_next = DRAIN;
      end
      DRAIN: begin
        oHistoLock = 1'b1;
        oBusy      = 1'b1;
        // Leave DRAIN the cycle after the LUT[255] write strobe.
        if (r_last_wr) w_next = CLEAR;
      end
      CLEAR: begin
        oHistoLock  = 1'b1;
        oBusy       = 1'b1;
        oHistoClear = 1'b1;
        if (w_clear_end) begin
          oDone  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read address: 0 in IDLE, counts 0..255 in ISSUE, holds 255 until IDLE.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdAddr <= '0;
    end else if (w_accept || w_clear_end) begin
      oRdAddr <= '0;
    end else if ((r_state == ISSUE) && (oRdAddr != 8'hFF)) begin
      oRdAddr <= oRdAddr + 8'd1;
    end
  end

  // Valid tag travels alongside each issued address for RD_LATENCY cycles.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= (r_state == ISSUE);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
    end
  end

  // CDF accumulation.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_acc     <= '0;
      r_in_idx  <= '0;
      r_acc_idx <= '0;
      r_acc_vld <= 1'b0;
    end else begin
      r_acc_vld <= w_in_vld;
      if (w_accept) begin
        r_acc    <= '0;
        r_in_idx <= '0;
      end else if (w_in_vld) begin
        r_acc     <= r_acc + iRdData;
        r_acc_idx <= r_in_idx;
        r_in_idx  <= r_in_idx + 8'd1;
      end
    end
  end

  // Registered scale stage feeding the LUT write port.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oLutWe    <= 1'b0;
      oLutAddr  <= '0;
      oLutData  <= '0;
      oCdfTotal <= '0;
      r_last_wr <= 1'b0;
    end else begin
      oLutWe    <= r_acc_vld;
      r_last_wr <= oLutWe && (oLutAddr == 8'hFF);
      if (r_acc_vld) begin
        oLutAddr <= r_acc_idx;
        oLutData <= w_code;
        if (r_acc_idx == 8'hFF) oCdfTotal <= r_acc;
      end
    end
  end

  // Clear-phase length counter.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_clr_cnt <= '0;
    end else if ((r_state == CLEAR) && !w_clear_end) begin
      r_clr_cnt <= r_clr_cnt + CNT_W'(1);
    end else begin
      r_clr_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_histogram_cdf_reader.sv
module tb_histogram_cdf_reader;

  localparam int NI = 3;
  localparam int C  = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start    [NI];
  logic [7:0]  rd_addr  [NI];
  logic [19:0] rd_data  [NI];
  logic        hclr     [NI];
  logic        lock     [NI];
  logic        we       [NI];
  logic [7:0]  lut_addr [NI];
  logic [7:0]  lut_data [NI];
  logic [19:0] cdf      [NI];
  logic        busy     [NI];
  logic        done     [NI];

  logic [19:0] hist  [256];
  logic [19:0] rpipe [NI][4];
  int          cyc = 0;

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;
  int run_id = 0;
  int seen_run = 0;

  int         wcnt[NI], first_wr[NI], last_wr[NI], done_cyc[NI], ndone[NI];
  int         nclr[NI], ngap[NI], naddr[NI], nmono[NI], nwe_clr[NI];
  logic [7:0] prev[NI];
  logic [7:0] lut[NI][256];

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      histogram_cdf_reader #(
        .RD_LATENCY  ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
        .BIN_W       (20),
        .SCALE       (11141),
        .SHIFT       (24),
        .CLEAR_CYCLES(C)
      ) u_dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iStart     (start[g]),
        .oRdAddr    (rd_addr[g]),
        .iRdData    (rd_data[g]),
        .oHistoClear(hclr[g]),
        .oHistoLock (lock[g]),
        .oLutWe     (we[g]),
        .oLutAddr   (lut_addr[g]),
        .oLutData   (lut_data[g]),
        .oCdfTotal  (cdf[g]),
        .oBusy      (busy[g]),
        .oDone      (done[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  // Histogram RAM read port model with per-instance latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      for (int s = 3; s > 0; s--) rpipe[g][s] <= rpipe[g][s-1];
      rpipe[g][0] <= hist[rd_addr[g]];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) rd_data[g] = rpipe[g][lat_of(g)-1];
  end

  // LUT write monitor.
  always @(negedge clk) begin
    if (seen_run != run_id) begin
      seen_run = run_id;
      for (int g = 0; g < NI; g++) begin
        wcnt[g] = 0; first_wr[g] = 0; last_wr[g] = 0; done_cyc[g] = 0;
        ndone[g] = 0; nclr[g] = 0; ngap[g] = 0; naddr[g] = 0;
        nmono[g] = 0; nwe_clr[g] = 0; prev[g] = 8'd0;
      end
    end
    for (int g = 0; g < NI; g++) begin
      if (we[g]) begin
        if (wcnt[g] > 0 && cyc != last_wr[g] + 1) ngap[g]++;
        if (wcnt[g] == 0) first_wr[g] = cyc;
        if (lut_addr[g] != 8'(wcnt[g])) naddr[g]++;
        if ((wcnt[g] % 256) != 0 && lut_data[g] < prev[g]) nmono[g]++;
        if (hclr[g]) nwe_clr[g]++;
        lut[g][lut_addr[g]] = lut_data[g];
        prev[g] = lut_data[g];
        last_wr[g] = cyc;
        wcnt[g]++;
      end
      if (hclr[g]) nclr[g]++;
      if (done[g]) begin
        ndone[g]++;
        done_cyc[g] = cyc;
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_code(input longint cum);
    longint p;
    p = (cum * 11141 + 64'd8388608) >> 24;
    return (p > 255) ? 255 : p;
  endfunction

  // 0: all pixels in bin 0, 1: uniform 1500, 2: all in bin 200, 3: 2000 per bin
  task automatic load(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       hist[i] = (i == 0) ? 20'd384000 : 20'd0;
        1:       hist[i] = 20'd1500;
        2:       hist[i] = (i == 200) ? 20'd384000 : 20'd0;
        default: hist[i] = 20'd2000;
      endcase
    end
  endtask

  task automatic outs_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s_L%0d", tag, lat_of(g)),
          longint'({we[g], hclr[g], lock[g], busy[g], done[g],
                    rd_addr[g], lut_addr[g], lut_data[g], cdf[g]}), 0);
    end
  endtask

  task automatic run_frame(input int mode, input bit extra);
    longint expc[256];
    longint cum;
    int     s_cyc;
    int     n;
    int     nbad;
    int     l;
    load(mode);
    cum = 0;
    for (int i = 0; i < 256; i++) begin
      cum = cum + longint'(hist[i]);
      expc[i] = exp_code(cum);
    end
    run_id++;
    for (int g = 0; g < NI; g++) start[g] = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    if (extra) begin
      repeat (48) @(negedge clk);
      for (int g = 0; g < NI; g++) start[g] = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) start[g] = 1'b0;
      n = 0;
      while (!(hclr[0] && hclr[1] && hclr[2]) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("wait_clear", longint'(n < 1000), 1);
      repeat (10) @(negedge clk);
      for (int g = 0; g < NI; g++) start[g] = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) start[g] = 1'b0;
    end
    n = 0;
    while ((ndone[0] == 0 || ndone[1] == 0 || ndone[2] == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", longint'(n < 2000), 1);
    repeat (5) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      l = lat_of(g);
      nbad = 0;
      for (int i = 0; i < 256; i++) if (longint'(lut[g][i]) != expc[i]) nbad++;
      chk($sformatf("m%0d_writes_L%0d", mode, l), wcnt[g], 256);
      chk($sformatf("m%0d_first_wr_L%0d", mode, l), first_wr[g] - s_cyc, l + 3);
      chk($sformatf("m%0d_done_at_L%0d", mode, l), done_cyc[g] - s_cyc, l + 259 + C);
      chk($sformatf("m%0d_ndone_L%0d", mode, l), ndone[g], 1);
      chk($sformatf("m%0d_clear_len_L%0d", mode, l), nclr[g], C);
      chk($sformatf("m%0d_gaps_L%0d", mode, l), ngap[g], 0);
      chk($sformatf("m%0d_addr_order_L%0d", mode, l), naddr[g], 0);
      chk($sformatf("m%0d_monotonic_L%0d", mode, l), nmono[g], 0);
      chk($sformatf("m%0d_we_in_clear_L%0d", mode, l), nwe_clr[g], 0);
      chk($sformatf("m%0d_lut_bad_L%0d", mode, l), nbad, 0);
      chk($sformatf("m%0d_cdf_L%0d", mode, l), cdf[g], cum & 64'hFFFFF);
      chk($sformatf("m%0d_idle_L%0d", mode, l),
          longint'({busy[g], lock[g], hclr[g], rd_addr[g]}), 0);
    end
  endtask

  initial begin
    int n;
    int snap[NI];
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    load(0);
    for (int g = 0; g < NI; g++) for (int s = 0; s < 4; s++) rpipe[g][s] = 20'd0;
    repeat (3) @(negedge clk);
    outs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All pixels in bin 0.
    run_frame(0, 1'b0);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("bin0_lut0_L%0d", lat_of(g)), lut[g][0], 255);
      chk($sformatf("bin0_lut255_L%0d", lat_of(g)), lut[g][255], 255);
      chk($sformatf("bin0_total_L%0d", lat_of(g)), cdf[g], 384000);
    end

    // Uniform, with ignored iStart pulses during ISSUE and CLEAR.
    run_frame(1, 1'b1);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("uni_lut0_L%0d", lat_of(g)), lut[g][0], 1);
      chk($sformatf("uni_lut100_L%0d", lat_of(g)), lut[g][100], 101);
      chk($sformatf("uni_lut255_L%0d", lat_of(g)), lut[g][255], 255);
    end

    // All pixels in bin 200.
    run_frame(2, 1'b0);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("b200_lut0_L%0d", lat_of(g)), lut[g][0], 0);
      chk($sformatf("b200_lut199_L%0d", lat_of(g)), lut[g][199], 0);
      chk($sformatf("b200_lut200_L%0d", lat_of(g)), lut[g][200], 255);
    end

    // Overfull frame: saturation, no wrap.
    run_frame(3, 1'b0);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("over_lut100_L%0d", lat_of(g)), lut[g][100], 134);
      chk($sformatf("over_lut192_L%0d", lat_of(g)), lut[g][192], 255);
      chk($sformatf("over_lut255_L%0d", lat_of(g)), lut[g][255], 255);
      chk($sformatf("over_total_L%0d", lat_of(g)), cdf[g], 512000);
    end

    // Asynchronous reset mid-sweep at bin 100.
    load(1);
    run_id++;
    for (int g = 0; g < NI; g++) start[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    n = 0;
    while (rd_addr[0] != 8'd100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bin100", longint'(n < 400), 1);
    #2 rst_n = 1'b0;
    #1 outs_zero("async_reset");
    @(negedge clk);
    for (int g = 0; g < NI; g++) snap[g] = wcnt[g];
    repeat (6) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("no_wr_in_reset_L%0d", lat_of(g)), wcnt[g], snap[g]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1, 1'b0);

    // iStart in the oDone cycle is ignored, accepted on the next IDLE cycle.
    load(2);
    run_id++;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_edge", longint'(n < 2000), 1);
    start[0] = 1'b1;
    @(negedge clk);
    chk("start_at_done_ignored", busy[0], 0);
    @(negedge clk);
    chk("start_after_done_busy", busy[0], 1);
    chk("start_after_done_addr", rd_addr[0], 0);
    start[0] = 1'b0;
    n = 0;
    while (ndone[0] < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_second_done", longint'(n < 2000), 1);
    repeat (3) @(negedge clk);
    chk("two_sweeps_writes", wcnt[0], 512);
    chk("two_sweeps_lut200", lut[0][200], 255);
    chk("two_sweeps_lut199", lut[0][199], 0);
    chk("two_sweeps_total", cdf[0], 384000);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
